// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - register file write-port arbiter for ALU and buffered load results
//
// Purpose:
//   Merges ALU results (one per cycle) and load results (variable latency,
//   buffered in a small FIFO) onto the single register file write port.
//   The ALU normally wins. A FIFO head that keeps losing is forced through
//   after STARVE_MAX lost cycles. Writes to x0 are accepted and dropped.
//   Also reports whether either issue-stage read address hits a queued load.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   aluValid/aluReady             ALU result handshake (aluReady combinational)
//   aluAddr, aluData              ALU destination register and result
//   loadValid/loadReady           load result handshake (loadReady registered)
//   loadAddr, loadData            load destination register and result
//   writeEn, writeAddr, writeData registered register file write port
//   addr1, addr2                  issue-stage read addresses
//   pending1, pending2            read address matches a queued load (combinational)
//   fifoCount                     current load FIFO occupancy
module regfile_writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aluValid,
  output logic                     aluReady,
  input  logic [4:0]               aluAddr,
  input  logic [31:0]              aluData,
  input  logic                     loadValid,
  output logic                     loadReady,
  input  logic [4:0]               loadAddr,
  input  logic [31:0]              loadData,
  output logic                     writeEn,
  output logic [4:0]               writeAddr,
  output logic [31:0]              writeData,
  input  logic [4:0]               addr1,
  input  logic [4:0]               addr2,
  output logic                     pending1,
  output logic                     pending2,
  output logic [$clog2(DEPTH):0]   fifoCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          load_ready_q;
  logic          write_en_q;
  logic [4:0]    write_addr_q;
  logic [31:0]   write_data_q;

  logic head_valid;
  logic starved;
  logic head_wins;
  logic alu_wins;
  logic push;
  logic pop;

  // Entries pushed this cycle only become visible through count_q next
  // cycle, so an empty FIFO never bypasses a new load to the write port.
  assign head_valid = (count_q != '0);
  assign starved    = (starve_q == SW'(STARVE_MAX));
  assign head_wins  = head_valid && (!aluValid || starved);
  assign alu_wins   = aluValid && !head_wins;
  // Loads to x0 complete the handshake but never occupy a slot.
  assign push       = loadValid && load_ready_q && (loadAddr != 5'd0);
  assign pop        = head_wins;
  assign count_d    = count_q + CW'(push) - CW'(pop);

  always_comb begin
    starve_d = starve_q;
    if (!head_valid || pop) begin
      starve_d = '0;
    end else if (alu_wins && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      load_ready_q <= 1'b1;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= loadAddr;
        fifo_data_q[wr_ptr_q] <= loadData;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q      <= count_d;
      // Registered ready: a pop from a full FIFO frees a slot one cycle later.
      load_ready_q <= (count_d != CW'(DEPTH));
      starve_q     <= starve_d;

      // Address/data hold their last value whenever nothing is written.
      if (head_wins) begin
        write_en_q   <= 1'b1;
        write_addr_q <= fifo_addr_q[rd_ptr_q];
        write_data_q <= fifo_data_q[rd_ptr_q];
      end else if (alu_wins && (aluAddr != 5'd0)) begin
        write_en_q   <= 1'b1;
        write_addr_q <= aluAddr;
        write_data_q <= aluData;
      end else begin
        write_en_q <= 1'b0;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    off      = '0;
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if ((addr1 != 5'd0) && (fifo_addr_q[i] == addr1)) pending1 = 1'b1;
        if ((addr2 != 5'd0) && (fifo_addr_q[i] == addr2)) pending2 = 1'b1;
      end
    end
  end

  assign aluReady  = !(head_wins && aluValid);
  assign loadReady = load_ready_q;
  assign writeEn   = write_en_q;
  assign writeAddr = write_addr_q;
  assign writeData = write_data_q;
  assign fifoCount = count_q;

endmodule
